// File: rtl/door_pkg.sv
// Shared types and defaults for the parking gate bank.
// Imported by the gate channel and the bank controller.
package door_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    OPEN,
    HOLD
  } door_state_t;

  localparam int DEF_OPEN_TICKS = 20;
  localparam int DEF_MAX_OPEN   = 2;

  // Width of at least one bit, even when $clog2 collapses to zero
  function automatic int clog2_safe(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/door_channel.sv
// One parking gate: request edge detect, state machine,
// blink counter and LED.
module door_channel
  import door_pkg::*;
#(
  parameter int OPEN_TICKS = DEF_OPEN_TICKS,
  parameter int CNT_W      = clog2_safe(OPEN_TICKS + 1)
) (
  input  logic clk_2Hz,
  input  logic reset,
  input  logic req,
  input  logic grant,
  input  logic obstruct,
  output logic is_pending,
  output logic is_busy,
  output logic busy_nxt,
  output logic led
);

  door_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_prev;
  logic             w_edge;
  logic             w_last;

  assign w_edge = req & ~r_prev;
  assign w_last = (r_cnt == CNT_W'(OPEN_TICKS));

  always_ff @(posedge clk_2Hz) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_prev <= req;
      unique case (r_state)
        IDLE: begin
          if (w_edge) r_state <= PENDING;
        end
        PENDING: begin
          if (grant) begin
            r_state <= OPEN;
            r_cnt   <= CNT_W'(1);
            r_led   <= 1'b1;
          end
        end
        OPEN: begin
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_led <= ~r_led;
          end else if (obstruct) begin
            r_state <= HOLD;
            r_led   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_led   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        HOLD: begin
          if (!obstruct) begin
            r_state <= IDLE;
            r_led   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lets the bank register a popcount that matches door_busy
  assign busy_nxt =
    ((r_state == PENDING) && grant) ||
    ((r_state == OPEN) && !(w_last && !obstruct)) ||
    ((r_state == HOLD) && obstruct);

  assign is_pending = (r_state == PENDING);
  assign is_busy    = (r_state == OPEN) || (r_state == HOLD);
  assign led        = r_led;

endmodule

// File: rtl/door_bank_ctrl.sv
// Bank of parking gates sharing a round-robin grant
// and a cap on simultaneously open gates.
module door_bank_ctrl
  import door_pkg::*;
#(
  parameter int N_DOORS    = 4,
  parameter int OPEN_TICKS = DEF_OPEN_TICKS,
  parameter int MAX_OPEN   = DEF_MAX_OPEN,
  parameter int CNT_W      = clog2_safe(OPEN_TICKS + 1)
) (
  input  logic                         clk_2Hz,
  input  logic                         reset,
  input  logic [N_DOORS-1:0]           open_req,
  input  logic [N_DOORS-1:0]           obstruct,
  output logic [N_DOORS-1:0]           door_led,
  output logic [N_DOORS-1:0]           door_busy,
  output logic [N_DOORS-1:0]           pending,
  output logic [$clog2(N_DOORS+1)-1:0] open_count
);

  localparam int OC_W = $clog2(N_DOORS + 1);
  localparam int PW   = clog2_safe(N_DOORS);

  logic [N_DOORS-1:0] w_grant;
  logic [N_DOORS-1:0] w_busy_nxt;
  logic [PW-1:0]      r_rr;
  logic [PW-1:0]      w_rr_nxt;
  logic [OC_W-1:0]    r_open_cnt;
  logic [OC_W-1:0]    w_cnt_nxt;
  logic               w_room;

  assign w_room = (r_open_cnt < OC_W'(MAX_OPEN));

  // Descending distance scan: the nearest pending gate from r_rr wins last
  always_comb begin
    w_grant  = '0;
    w_rr_nxt = r_rr;
    for (int k = N_DOORS - 1; k >= 0; k--) begin
      for (int i = 0; i < N_DOORS; i++) begin
        if (w_room && pending[i] &&
            ((int'(r_rr) + k) % N_DOORS == i)) begin
          w_grant    = '0;
          w_grant[i] = 1'b1;
          w_rr_nxt   = PW'((i + 1) % N_DOORS);
        end
      end
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      w_cnt_nxt = w_cnt_nxt + OC_W'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk_2Hz) begin
    if (!reset) begin
      r_rr       <= '0;
      r_open_cnt <= '0;
    end else begin
      r_rr       <= w_rr_nxt;
      r_open_cnt <= w_cnt_nxt;
    end
  end

  assign open_count = r_open_cnt;

  for (genvar g = 0; g < N_DOORS; g++) begin : g_ch
    door_channel #(
      .OPEN_TICKS(OPEN_TICKS),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk_2Hz   (clk_2Hz),
      .reset     (reset),
      .req       (open_req[g]),
      .grant     (w_grant[g]),
      .obstruct  (obstruct[g]),
      .is_pending(pending[g]),
      .is_busy   (door_busy[g]),
      .busy_nxt  (w_busy_nxt[g]),
      .led       (door_led[g])
    );
  end

endmodule

// File: tb/tb_door_bank_ctrl.sv
// Directed bench for door_bank_ctrl: one bank capped at two
// open gates, a second bank capped at four for round-robin.
module tb_door_bank_ctrl;

  logic       clk_2Hz = 1'b0;
  logic       reset;
  logic [3:0] open_req, obstruct;
  logic [3:0] open_req4, obstruct4;
  logic [3:0] door_led, door_busy, pending;
  logic [3:0] led4, busy4, pend4;
  logic [2:0] open_count, cnt4;
  logic [14:0] obs, obs4, exp;
  int checks = 0;
  int errors = 0;

  always #5 clk_2Hz = ~clk_2Hz;

  assign obs  = {door_led, door_busy, pending, open_count};
  assign obs4 = {led4, busy4, pend4, cnt4};

  door_bank_ctrl #(
    .N_DOORS(4), .OPEN_TICKS(20), .MAX_OPEN(2)
  ) u_dut (
    .clk_2Hz   (clk_2Hz),
    .reset     (reset),
    .open_req  (open_req),
    .obstruct  (obstruct),
    .door_led  (door_led),
    .door_busy (door_busy),
    .pending   (pending),
    .open_count(open_count)
  );

  door_bank_ctrl #(
    .N_DOORS(4), .OPEN_TICKS(20), .MAX_OPEN(4)
  ) u_dut4 (
    .clk_2Hz   (clk_2Hz),
    .reset     (reset),
    .open_req  (open_req4),
    .obstruct  (obstruct4),
    .door_led  (led4),
    .door_busy (busy4),
    .pending   (pend4),
    .open_count(cnt4)
  );

  task automatic tick();
    @(posedge clk_2Hz);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    open_req  = '0;
    obstruct  = '0;
    open_req4 = '0;
    obstruct4 = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    open_req  = 4'hF;
    obstruct  = 4'hF;
    open_req4 = 4'hF;
    obstruct4 = 4'hF;
    tick();
    tick();
    exp = '0;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, exp);
    end
    checks++;
    if (obs4 !== exp) begin
      errors++;
      $display("FAIL reset4: got %b want %b", obs4, exp);
    end
    checks++;
  endtask

  task automatic test_single();
    do_reset();
    open_req = 4'b0001;
    tick();
    exp = {4'b0000, 4'b0000, 4'b0001, 3'd0};
    if (obs !== exp) begin
      errors++;
      $display("FAIL single_pend: got %b want %b", obs, exp);
    end
    checks++;
    open_req = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = {3'b000, (c % 2 == 1), 4'b0001, 4'b0000, 3'd1};
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_c%0d: got %b want %b", c, obs, exp);
      end
      checks++;
    end
    tick();
    exp = '0;
    if (obs !== exp) begin
      errors++;
      $display("FAIL single_close: got %b want %b", obs, exp);
    end
    checks++;
  endtask

  task automatic test_cap();
    do_reset();
    open_req = 4'b0111;
    tick();
    exp = {4'b0000, 4'b0000, 4'b0111, 3'd0};
    if (obs !== exp) begin
      errors++;
      $display("FAIL cap_pend: got %b want %b", obs, exp);
    end
    checks++;
    open_req = '0;
    tick();
    exp = {4'b0001, 4'b0001, 4'b0110, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL cap_g0: got %b want %b", obs, exp);
    end
    checks++;
    tick();
    exp = {4'b0010, 4'b0011, 4'b0100, 3'd2};
    if (obs !== exp) begin
      errors++;
      $display("FAIL cap_g1: got %b want %b", obs, exp);
    end
    checks++;
    for (int c = 3; c <= 20; c++) begin
      tick();
      exp = {2'b00, (c % 2 == 0), (c % 2 == 1),
             4'b0011, 4'b0100, 3'd2};
      if (obs !== exp) begin
        errors++;
        $display("FAIL cap_c%0d: got %b want %b", c, obs, exp);
      end
      checks++;
    end
    tick();
    exp = {4'b0000, 4'b0010, 4'b0100, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL cap_close0: got %b want %b", obs, exp);
    end
    checks++;
    tick();
    exp = {4'b0100, 4'b0100, 4'b0000, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL cap_g2: got %b want %b", obs, exp);
    end
    checks++;
  endtask

  task automatic test_obstruct();
    do_reset();
    open_req = 4'b0010;
    tick();
    open_req = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 15) obstruct = 4'b0010;
      tick();
      exp = {2'b00, (c % 2 == 1), 1'b0,
             4'b0010, 4'b0000, 3'd1};
      if (obs !== exp) begin
        errors++;
        $display("FAIL obst_c%0d: got %b want %b", c, obs, exp);
      end
      checks++;
    end
    for (int h = 0; h < 6; h++) begin
      tick();
      exp = {4'b0010, 4'b0010, 4'b0000, 3'd1};
      if (obs !== exp) begin
        errors++;
        $display("FAIL obst_hold%0d: got %b want %b", h, obs, exp);
      end
      checks++;
    end
    obstruct = '0;
    tick();
    exp = '0;
    if (obs !== exp) begin
      errors++;
      $display("FAIL obst_release: got %b want %b", obs, exp);
    end
    checks++;
  endtask

  task automatic test_retrigger();
    do_reset();
    open_req = 4'b0001;
    tick();
    open_req = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 11) open_req = 4'b0001;
      if (c == 13) open_req = 4'b0000;
      tick();
      exp = {3'b000, (c % 2 == 1), 4'b0001, 4'b0000, 3'd1};
      if (obs !== exp) begin
        errors++;
        $display("FAIL retrig_c%0d: got %b want %b", c, obs, exp);
      end
      checks++;
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      exp = '0;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retrig_end%0d: got %b want %b", t, obs, exp);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    open_req = 4'b0001;
    tick();
    open_req = 4'b0010;
    tick();
    exp = {4'b0001, 4'b0001, 4'b0010, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_req_grant: got %b want %b", obs, exp);
    end
    checks++;
    open_req = '0;
    tick();
    exp = {4'b0010, 4'b0011, 4'b0000, 3'd2};
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_g1: got %b want %b", obs, exp);
    end
    checks++;
    for (int c = 3; c <= 20; c++) tick();
    open_req = 4'b0100;
    tick();
    exp = {4'b0000, 4'b0010, 4'b0100, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_close_req: got %b want %b", obs, exp);
    end
    checks++;
    open_req = '0;
    tick();
    exp = {4'b0100, 4'b0100, 4'b0000, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_g2: got %b want %b", obs, exp);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    open_req = 4'b0011;
    tick();
    open_req = 4'b0001;
    for (int c = 1; c <= 7; c++) tick();
    exp = {4'b0001, 4'b0011, 4'b0000, 3'd2};
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_pre: got %b want %b", obs, exp);
    end
    checks++;
    reset = 1'b0;
    tick();
    exp = '0;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_reset: got %b want %b", obs, exp);
    end
    checks++;
    reset = 1'b1;
    tick();
    exp = {4'b0000, 4'b0000, 4'b0001, 3'd0};
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_held_req: got %b want %b", obs, exp);
    end
    checks++;
    tick();
    exp = {4'b0001, 4'b0001, 4'b0000, 3'd1};
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_grant: got %b want %b", obs, exp);
    end
    checks++;
    open_req = '0;
  endtask

  task automatic test_round_robin();
    logic [14:0] tbl [4];
    tbl[0] = {4'b0100, 4'b0100, 4'b1011, 3'd1};
    tbl[1] = {4'b1000, 4'b1100, 4'b0011, 3'd2};
    tbl[2] = {4'b0101, 4'b1101, 4'b0010, 3'd3};
    tbl[3] = {4'b1010, 4'b1111, 4'b0000, 3'd4};
    do_reset();
    open_req4 = 4'b0011;
    tick();
    open_req4 = '0;
    for (int c = 0; c < 22; c++) tick();
    exp = '0;
    if (obs4 !== exp) begin
      errors++;
      $display("FAIL rr_drain: got %b want %b", obs4, exp);
    end
    checks++;
    open_req4 = 4'b1111;
    tick();
    exp = {4'b0000, 4'b0000, 4'b1111, 3'd0};
    if (obs4 !== exp) begin
      errors++;
      $display("FAIL rr_pend: got %b want %b", obs4, exp);
    end
    checks++;
    open_req4 = '0;
    for (int s = 0; s < 4; s++) begin
      tick();
      if (obs4 !== tbl[s]) begin
        errors++;
        $display("FAIL rr_step%0d: got %b want %b", s, obs4, tbl[s]);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cap();
    test_obstruct();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
